// File: rtl/div.sv
// div -- multi-cycle radix-2 restoring integer divider (DIV/DIVU) for EX.
//
// One quotient bit is produced per clock. A nonzero divide takes 32 iterations
// after the accepting edge. A zero divisor returns 0 after one extra edge.
// The result {remainder, quotient} stays valid while ready_o=1. It is held for
// as long as start_i stays high.
//
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined, an accepted
// request with |divisor| > |dividend| completes at the accepting edge with
// result {dividend, 0}.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   signed_div_i 1 = DIV (signed), 0 = DIVU; sampled with the accepted start
//   opdata1_i    dividend (rs), captured once at the accepting edge
//   opdata2_i    divisor  (rt), captured once at the accepting edge
//   start_i      request, held by EX until ready_o is seen
//   annul_i      abort in-flight divide; also blocks a new start
//   result_o     {remainder, quotient}, valid while ready_o=1
//   ready_o      result valid
//   busy_o       divide in progress (ByZero/On), used as stall request
module div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // |divisor|
  logic               sdiv_q, sdiv_d;
  logic               s1_q, s1_d;     // dividend sign
  logic               s2_q, s2_d;     // divisor sign
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // Operand magnitudes. Negation applies only to signed requests. 0x80000000
  // negates to itself, which is the correct unsigned magnitude.
  logic             op1_neg, op2_neg, start_ok, early;
  logic [WIDTH-1:0] abs1, abs2;
  assign op1_neg  = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg  = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1     = op1_neg ? -opdata1_i : opdata1_i;
  assign abs2     = op2_neg ? -opdata2_i : opdata2_i;
  assign start_ok = start_i & ~annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs2 > abs1);
`else
  assign early = 1'b0;
`endif

  // One restoring step. The shifted remainder {rem, next dividend bit} is
  // WIDTH+1 bits wide. Because rem < divisor, the WIDTH+1-bit difference has
  // its sign bit set exactly when the trial subtraction underflows.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx, quo_nx, q_fix, r_fix;
  logic             last;
  assign trial  = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_nx = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  assign last   = (cnt_q == CNT_W'(WIDTH-1));
  // The remainder takes the sign of the dividend.
  assign q_fix  = (sdiv_q & (s1_q ^ s2_q)) ? -quo_nx : quo_nx;
  assign r_fix  = (sdiv_q & s1_q) ? -rem_nx : rem_nx;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sdiv_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sdiv_q   <= sdiv_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FREE: begin
        if (start_ok) begin
          if (opdata2_i == '0) state_d = S_BYZERO;
          else if (early)      state_d = S_END;
          else                 state_d = S_ON;
        end
      end
      S_BYZERO: state_d = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)   state_d = S_FREE;
        else if (last) state_d = S_END;
      end
      S_END:   state_d = start_i ? S_END : S_FREE;
      default: state_d = S_FREE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sdiv_d   = sdiv_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = '0;
    ready_d  = (state_d == S_END);
    case (state_q)
      S_FREE: begin
        if (start_ok && opdata2_i != '0) begin
          if (early) begin
            result_d = {opdata1_i, {WIDTH{1'b0}}};
          end else begin
            rem_d  = '0;
            quo_d  = abs1;
            dvs_d  = abs2;
            cnt_d  = '0;
            sdiv_d = signed_div_i;
            s1_d   = op1_neg;
            s2_d   = op2_neg;
          end
        end
      end
      S_ON: begin
        if (!annul_i) begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 1'b1;
          if (last) result_d = {r_fix, q_fix};
        end
      end
      S_END:   if (start_i) result_d = result_q;
      default: ;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q == S_BYZERO) || (state_q == S_ON);

endmodule

// File: tb/tb_div.sv
module tb_div;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           signed_div_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  div #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] sb[$];

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] x);
    return (s && x[W-1]) ? -x : x;
  endfunction

  // Expected edge index (E0 = accepting edge) at which ready_o rises
  function automatic int exp_lat(input vec_t v);
    if (v.b == '0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(v.sgn, v.b) > mag(v.sgn, v.a)) return 0;
`endif
    return 32;
  endfunction

  task automatic run_vec(input vec_t v);
    int idx, lat;
    bit got;
    logic [2*W-1:0] e;
    @(negedge clk);
    signed_div_i = v.sgn; opdata1_i = v.a; opdata2_i = v.b; start_i = 1'b1;
    sb.push_back(v.exp);
    lat = exp_lat(v);
    idx = 0; got = 0;
    while (!got && idx < 40) begin
      @(posedge clk); #1;
      // operands are captured once; scramble them afterwards
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~v.sgn;
      if (ready_o) got = 1;
      else begin
        if (idx == 0) chk({v.name, " busy"}, {63'd0, busy_o}, 64'd1);
        idx++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      chk({v.name, " timeout"}, 64'd0, 64'd1);
    end else begin
      chk({v.name, " result"}, result_o, e);
      chk({v.name, " latency"}, 64'(idx), 64'(lat));
      chk({v.name, " busy_end"}, {63'd0, busy_o}, 64'd0);
      @(posedge clk); #1;                 // start still high: hold
      chk({v.name, " hold"}, {result_o[2*W-2:0], ready_o}, {e[2*W-2:0], 1'b1});
    end
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " drop"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    bit seen;
    vecs.push_back('{"u100_7",   1'b0, 32'd100,       32'd7,         {32'h2,        32'hE}});
    vecs.push_back('{"s-7_2",    1'b1, 32'hFFFFFFF9,  32'h2,         {32'hFFFFFFFF, 32'hFFFFFFFD}});
    vecs.push_back('{"s7_-2",    1'b1, 32'h7,         32'hFFFFFFFE,  {32'h1,        32'hFFFFFFFD}});
    vecs.push_back('{"u5_0",     1'b0, 32'd5,         32'd0,         64'd0});
    vecs.push_back('{"s-5_0",    1'b1, 32'hFFFFFFFB,  32'd0,         64'd0});
    vecs.push_back('{"s_min_-1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0,        32'h80000000}});
    vecs.push_back('{"u0_5",     1'b0, 32'd0,         32'd5,         64'd0});
    vecs.push_back('{"u3_10",    1'b0, 32'd3,         32'd10,        {32'h3,        32'h0}});
    vecs.push_back('{"umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0,        32'hFFFFFFFF}});
    vecs.push_back('{"umax_m1",  1'b0, 32'hFFFFFFFF,  32'hFFFFFFFE,  {32'h1,        32'h1}});
    vecs.push_back('{"s-100_-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE, 32'hE}});
    vecs.push_back('{"u_min_m1", 1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'h0}});
    vecs.push_back('{"s-3_10",   1'b1, 32'hFFFFFFFD,  32'd10,        {32'hFFFFFFFD, 32'h0}});

    // reset state
    #3;
    chk("reset", {result_o[2*W-1:2], ready_o, busy_o}, 64'd0);
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // annul at E10 during On
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);          // E0..E9
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;                  // E10
    chk("annul", {62'd0, ready_o, busy_o}, 64'd0);
    @(negedge clk); annul_i = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen = 1; end
    chk("annul_noresult", {63'd0, seen}, 64'd0);
    run_vec('{"u9_3_after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}});

    // reset at iteration 15
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (16) @(posedge clk);          // E0..E15
    #2;
    chk("busy_pre_rst", {63'd0, busy_o}, 64'd1);
    rst = 1'b0; start_i = 1'b0;
    #1;
    chk("mid_reset", {result_o[2*W-1:2], ready_o, busy_o}, 64'd0);
    @(negedge clk); rst = 1'b1;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ready_o || busy_o) seen = 1; end
    chk("post_reset_idle", {63'd0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
